// File: rtl/cache_pkg.sv
// cache_pkg: shared sizes, FSM state encoding and tag-entry layout for the
// two-way set-associative cache controller.
package cache_pkg;

  localparam int INDEX_W  = 6;
  localparam int TAG_W    = 14;
  localparam int NUM_WAYS = 2;
  localparam int NUM_SETS = 1 << INDEX_W;

  // Controller sequencing: one request in flight at a time
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    REFILL,
    WRITE
  } state_e;

  // One way's bookkeeping for one set
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: flop-based tag/valid store for 64 sets x 2 ways plus one
// LRU bit per set. Combinational read port, single synchronous write port.
// Everything clears on the asynchronous reset so a reset invalidates the cache.
module cache_tag_array
  import cache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic [1:0]         rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag0_o,
  output logic [TAG_W-1:0]   rd_tag1_o,
  output logic               rd_lru_o,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               tag_we_i,
  input  logic               tag_way_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               lru_we_i,
  input  logic               lru_i
);

  tag_entry_t              entries_q [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0]     lru_q;

  // Tag writes only come from refills, which always leave the entry valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          entries_q[s][w] <= '0;
        end
      end
      lru_q <= '0;
    end else begin
      if (tag_we_i) begin
        entries_q[wr_idx_i][tag_way_i] <= '{valid: 1'b1, tag: tag_i};
      end
      if (lru_we_i) begin
        lru_q[wr_idx_i] <= lru_i;
      end
    end
  end

  assign rd_valid_o = {entries_q[rd_idx_i][1].valid, entries_q[rd_idx_i][0].valid};
  assign rd_tag0_o  = entries_q[rd_idx_i][0].tag;
  assign rd_tag1_o  = entries_q[rd_idx_i][1].tag;
  assign rd_lru_o   = lru_q[rd_idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: two-way set-associative, write-through, no-write-allocate cache
// controller. Owns tag/valid/LRU state, steers hits to the external way banks
// and fetches one word from memory on a read miss.
// Optional feature macro: CACHE_UNCACHED_KSEG1_EN (addr[31:29]==3'b101 is
// treated as uncached: forced miss, no bank write, no tag/LRU update).
module cache_ctrl
  import cache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  output logic        cpu_ready_o,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_wstrb_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [31:0] cpu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  way_en_o,
  output logic [3:0]  way_wen_o,
  output logic [31:0] way_addr_w_o,
  output logic [31:0] way_data_w_o,
  output logic        way_refill_o,
  output logic [1:0]  way_en_r_o,
  output logic [31:0] way_addr_r_o,
  input  logic [31:0] way0_data_r_i,
  input  logic [31:0] way1_data_r_i
);

  state_e             state_q;
  logic [31:0]        addr_q;
  logic               we_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        wdata_q;
  logic               cpu_ready_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [3:0]         mem_wstrb_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        mem_wdata_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         rd_valid;
  logic [TAG_W-1:0]   rd_tag0;
  logic [TAG_W-1:0]   rd_tag1;
  logic               rd_lru;
  logic               uncached;
  logic               hit0;
  logic               hit1;
  logic               hit_any;
  logic               hit_way;
  logic               victim_way;

  logic               tag_we_d;
  logic               tag_way_d;
  logic               lru_we_d;
  logic               lru_d;

  assign idx     = addr_q[INDEX_W-1:0];
  assign req_tag = addr_q[INDEX_W+TAG_W-1:INDEX_W];

`ifdef CACHE_UNCACHED_KSEG1_EN
  assign uncached = (addr_q[31:29] == 3'b101);
`else
  assign uncached = 1'b0;
`endif

  cache_tag_array u_tag_array (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_idx_i   (idx),
    .rd_valid_o (rd_valid),
    .rd_tag0_o  (rd_tag0),
    .rd_tag1_o  (rd_tag1),
    .rd_lru_o   (rd_lru),
    .wr_idx_i   (idx),
    .tag_we_i   (tag_we_d),
    .tag_way_i  (tag_way_d),
    .tag_i      (req_tag),
    .lru_we_i   (lru_we_d),
    .lru_i      (lru_d)
  );

  // Way0 wins if both ways ever match; the victim is the first invalid way, else LRU
  assign hit0       = !uncached && rd_valid[0] && (rd_tag0 == req_tag);
  assign hit1       = !uncached && rd_valid[1] && (rd_tag1 == req_tag);
  assign hit_any    = hit0 || hit1;
  assign hit_way    = hit0 ? 1'b0 : 1'b1;
  assign victim_way = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : rd_lru);

  // Bank reads are launched straight from the incoming request so data lands in LOOKUP
  assign way_en_r_o   = (state_q == IDLE && cpu_req_i) ? 2'b11 : 2'b00;
  assign way_addr_r_o = (state_q == IDLE && cpu_req_i) ? cpu_addr_i : 32'h0;

  // Same-cycle responses: hit data, refill write, store-hit write and completion pulse
  always_comb begin
    tag_we_d     = 1'b0;
    tag_way_d    = 1'b0;
    lru_we_d     = 1'b0;
    lru_d        = 1'b0;
    way_en_o     = 2'b00;
    way_wen_o    = 4'h0;
    way_addr_w_o = 32'h0;
    way_data_w_o = 32'h0;
    way_refill_o = 1'b0;
    cpu_ack_o    = 1'b0;
    cpu_rdata_o  = 32'h0;
    case (state_q)
      LOOKUP: begin
        if (hit_any) begin
          lru_we_d = 1'b1;
          lru_d    = ~hit_way;
          if (!we_q) begin
            cpu_ack_o   = 1'b1;
            cpu_rdata_o = hit0 ? way0_data_r_i : way1_data_r_i;
          end else begin
            way_en_o     = hit0 ? 2'b01 : 2'b10;
            way_wen_o    = wstrb_q;
            way_addr_w_o = addr_q;
            way_data_w_o = wdata_q;
          end
        end
      end
      REFILL: begin
        if (mem_rvalid_i) begin
          cpu_ack_o   = 1'b1;
          cpu_rdata_o = mem_rdata_i;
          if (!uncached) begin
            way_en_o     = victim_way ? 2'b10 : 2'b01;
            way_wen_o    = 4'hF;
            way_addr_w_o = addr_q;
            way_data_w_o = mem_rdata_i;
            way_refill_o = 1'b1;
            tag_we_d     = 1'b1;
            tag_way_d    = victim_way;
            lru_we_d     = 1'b1;
            lru_d        = ~victim_way;
          end
        end
      end
      WRITE: begin
        cpu_ack_o = mem_gnt_i;
      end
      default: begin
      end
    endcase
  end

  // Request sequencing with registered handshake and memory command outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      cpu_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            addr_q      <= cpu_addr_i;
            we_q        <= cpu_we_i;
            wstrb_q     <= cpu_wstrb_i;
            wdata_q     <= cpu_wdata_i;
            cpu_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!we_q && hit_any) begin
            cpu_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_q;
            mem_wstrb_q <= we_q ? wstrb_q : 4'h0;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= we_q ? wdata_q : 32'h0;
            state_q     <= we_q ? WRITE : MISS;
          end
        end
        MISS: begin
          if (mem_gnt_i) begin
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            state_q     <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid_i) begin
            cpu_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        WRITE: begin
          if (mem_gnt_i) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready_o = cpu_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
